u_enc: RTL and testbench

Streaming binary-to-unary (thermometer) encoder; the generating counterpart of the unary admission checker. It accepts a count `k` and a complement select over a valid/ready handshake and emits the W-bit unary code: `k` ones in the low bits, or the bitwise complement of that code. Every non-error output is a code the admission checker accepts when instantiated with the same `W` and complement enable. Output is registered behind a 2-entry skid buffer, so all handshake paths are register-terminated.

---
 rtl/u_enc.sv | 133 +++++++++++++
 tb/tb_u_enc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_enc.sv
// rtl/u_enc.sv - streaming binary-to-unary (thermometer) encoder with 2-entry skid output
//
// Purpose: accepts a count k and a complement select, emits the W-bit unary
// code (k ones in the low bits, or its bitwise complement). Out-of-range
// requests (k >= W) produce an all-zero code flagged with o_out_err and
// bump a saturating error counter. Output is held in a main register backed
// by a skid register so every handshake path is register-terminated.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   i_in_valid   request valid
//   i_in_k       requested count (legal 0..W-1)
//   i_in_inv     request complement code
//   o_in_ready   encoder can accept a request
//   o_out_valid  output code valid
//   o_out_x      unary code
//   o_out_err    request was out of range (o_out_x is zero)
//   i_out_ready  downstream accepts the output
//   o_err_cnt    saturating count of accepted out-of-range requests

module u_enc #(
  parameter int W                    = 16,
  parameter int P_EMIT_COMPLIMENT_EN = 1,
  localparam int KW                  = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  input  logic [KW-1:0] i_in_k,
  input  logic          i_in_inv,
  output logic          o_in_ready,
  output logic          o_out_valid,
  output logic [W-1:0]  o_out_x,
  output logic          o_out_err,
  input  logic          i_out_ready,
  output logic [7:0]    o_err_cnt
);

  logic [W-1:0] main_x_q, main_x_d, skid_x_q, skid_x_d;
  logic         main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  logic [W-1:0] code;
  logic [W-1:0] enc_x;
  logic         enc_err;
  logic         accept;
  logic         deliver;

  // Encode once on the accept path; the output side only moves stored codes.
  always_comb begin
    code    = '0;
    enc_err = (int'(i_in_k) >= W);
    for (int j = 0; j < W; j++) begin
      code[j] = (j < int'(i_in_k));
    end
    if (enc_err) begin
      enc_x = '0;
    end else if ((P_EMIT_COMPLIMENT_EN != 0) && i_in_inv) begin
      enc_x = ~code;
    end else begin
      enc_x = code;
    end
  end

  // Ready is gated by rst_n so nothing is taken while reset is asserted;
  // otherwise it depends on the skid register alone.
  assign o_in_ready = rst_n & ~skid_valid_q;
  assign accept     = i_in_valid & o_in_ready;
  assign deliver    = main_valid_q & i_out_ready;

  always_comb begin
    main_x_d     = main_x_q;
    main_err_d   = main_err_q;
    main_valid_d = main_valid_q;
    skid_x_d     = skid_x_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;
    err_cnt_d    = err_cnt_q;

    if (deliver && skid_valid_q) begin
      // No accept is possible while skid is full, so only the shift happens.
      main_x_d     = skid_x_q;
      main_err_d   = skid_err_q;
      main_valid_d = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || deliver)) begin
      main_x_d     = enc_x;
      main_err_d   = enc_err;
      main_valid_d = 1'b1;
    end else begin
      if (deliver) begin
        main_valid_d = 1'b0;
      end
      if (accept) begin
        skid_x_d     = enc_x;
        skid_err_d   = enc_err;
        skid_valid_d = 1'b1;
      end
    end

    if (accept && enc_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_x_q     <= '0;
      main_err_q   <= 1'b0;
      main_valid_q <= 1'b0;
      skid_x_q     <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      main_x_q     <= main_x_d;
      main_err_q   <= main_err_d;
      main_valid_q <= main_valid_d;
      skid_x_q     <= skid_x_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_out_valid = main_valid_q;
  assign o_out_x     = main_x_q;
  assign o_out_err   = main_err_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_u_enc.sv
// tb/tb_u_enc.sv - randomized self-checking bench for u_enc against a queue-based model

module tb_u_enc;

  localparam int W  = 16;
  localparam int KW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [KW-1:0] in_k = '0;
  logic          in_inv = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_x;
  logic          out_err;
  logic          out_ready = 1'b0;
  logic [7:0]    err_cnt;

  logic          v0 = 1'b0;
  logic [KW-1:0] k0 = '0;
  logic          inv0 = 1'b0;
  logic          rdy0;
  logic          ov0;
  logic [W-1:0]  x0;
  logic          e0;
  logic [7:0]    cnt0;

  always #5 clk = ~clk;

  u_enc #(.W(W), .P_EMIT_COMPLIMENT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .i_in_k(in_k), .i_in_inv(in_inv),
    .o_in_ready(in_ready), .o_out_valid(out_valid), .o_out_x(out_x), .o_out_err(out_err),
    .i_out_ready(out_ready), .o_err_cnt(err_cnt)
  );

  u_enc #(.W(W), .P_EMIT_COMPLIMENT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v0), .i_in_k(k0), .i_in_inv(inv0),
    .o_in_ready(rdy0), .o_out_valid(ov0), .o_out_x(x0), .o_out_err(e0),
    .i_out_ready(1'b1), .o_err_cnt(cnt0)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, code} from arithmetic on k.
  function automatic logic [16:0] exp_code(input int k, input bit inv, input bit en);
    int c;
    if (k >= W) return {1'b1, 16'h0000};
    c = (1 << k) - 1;
    if (inv && en) c = ~c;
    return {1'b0, c[15:0]};
  endfunction

  // Admission-checker model: any thermometer code or (if enabled) its complement.
  function automatic bit is_unary(input logic [15:0] x, input bit en);
    for (int k = 0; k < W; k++) begin
      if (x == exp_code(k, 1'b0, 1'b0)) return 1'b1;
      if (en && x == exp_code(k, 1'b1, 1'b1)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // out_ready policy: 0 = stall, 1 = always ready, 2 = random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = 1'b1 & $urandom_range(0, 1);
    endcase
  end

  // Scoreboard, evaluated at negedge for the handshakes of the coming edge.
  logic [16:0] q[$];
  int          m_cnt = 0;
  bit          mon_on = 1'b0;
  bit          held_v = 1'b0;
  logic [16:0] held;
  bit          lat_on = 1'b0;
  bit          lat_pend = 1'b0;
  logic [16:0] lat_exp;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      logic [16:0] e;
      chk("err_cnt", {24'd0, err_cnt}, m_cnt);
      if (held_v) chk("stall_stable", {out_valid, out_err, out_x}, {1'b1, held});
      if (lat_pend) chk("latency", {out_valid, out_err, out_x}, {1'b1, lat_exp});
      lat_pend = 1'b0;
      if (!rst_n) begin
        q.delete();
        m_cnt  = 0;
        held_v = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("out_code", {15'd0, out_err, out_x}, {15'd0, e});
            if (!out_err) chk("checker_accepts", {31'd0, is_unary(out_x, 1'b1)}, 32'd1);
          end
        end
        if (in_valid && in_ready) begin
          e = exp_code(int'(in_k), in_inv, 1'b1);
          q.push_back(e);
          if (e[16] && m_cnt < 255) m_cnt++;
          if (lat_on) begin
            lat_pend = 1'b1;
            lat_exp  = e;
          end
        end
        held_v = out_valid && !out_ready;
        held   = {out_err, out_x};
      end
    end
  end

  task automatic send(input int k, input bit inv);
    int  n = 0;
    bit  acc;
    in_valid = 1'b1;
    in_k     = k[KW-1:0];
    in_inv   = inv;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int n;
    logic [16:0] e;

    // Reset state
    @(posedge clk); #1;
    mon_on = 1'b1;
    wait_cycles(2);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_x", {16'd0, out_x}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rdy_mode = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back sweep, 1-cycle latency, one per cycle
    lat_on = 1'b1;
    t0 = cyc;
    for (int inv = 0; inv < 2; inv++)
      for (int k = 0; k < W; k++) send(k, inv[0]);
    chk("sweep_throughput", cyc - t0, 32);
    wait_cycles(1);
    @(negedge clk);
    lat_on = 1'b0;
    @(posedge clk); #1;

    // Out of range followed by a normal request
    send(16, 1'b1);
    send(2, 1'b0);
    @(negedge clk);
    chk("oor_cnt", {24'd0, err_cnt}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: k=1 main, k=2 skid, k=3 held off
    rdy_mode = 0;
    wait_cycles(2);
    send(1, 1'b0);
    send(2, 1'b0);
    in_valid = 1'b1; in_k = 5'd3; in_inv = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("full_not_ready", {31'd0, in_ready}, 32'd0);
      chk("full_main", {15'd0, out_err, out_x}, 32'h0001);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    send(3, 1'b0);
    wait_cycles(4);

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send($urandom_range(0, 20), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
    end

    // Saturation of the error counter
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) send($urandom_range(16, 31), 1'($urandom_range(0, 1)));
    wait_cycles(3);
    @(negedge clk);
    chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
    @(posedge clk); #1;

    // Reset with main and skid full
    rdy_mode = 0;
    wait_cycles(2);
    send(5, 1'b0);
    send(6, 1'b1);
    @(negedge clk);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rdy_mode = 1;
    wait_cycles(8);

    // Drain and confirm nothing is left outstanding
    n = 0;
    while (q.size() != 0 && n < 100) begin wait_cycles(1); n++; end
    chk("drained", q.size(), 0);

    // Complement disabled: inv is ignored
    for (int i = 0; i < 10; i++) begin
      int  k = (i == 0) ? 4 : $urandom_range(0, 15);
      bit  inv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      e = exp_code(k, inv, 1'b0);
      v0 = 1'b1; k0 = k[KW-1:0]; inv0 = inv;
      @(negedge clk);
      chk("noinv_ready", {31'd0, rdy0}, 32'd1);
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk);
      chk("noinv_code", {15'd0, ov0, e0, x0}, {15'd0, 1'b1, e});
      if (i == 0) chk("noinv_k4", {16'd0, x0}, 32'h000F);
      chk("noinv_checker", {31'd0, is_unary(x0, 1'b0)}, 32'd1);
      @(posedge clk); #1;
    end
    chk("noinv_cnt", {24'd0, cnt0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
